// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: shares the 4x8 register file write port between requesters A and B
//
// Ports:
//   clk, _reset             clock (rising edge) and asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data   requester A (ALU result) handshake and payload
//   b_valid/b_ready/b_addr/b_data   requester B (load / immediate) handshake and payload
//   _wr_en, wr_addr, wr_data        register file write port; the file latches on the rising edge of _wr_en
//   busy, last_grant                write in flight; 0 = A won the last arbitration, 1 = B
//   rdL_addr/rdR_addr -> rdL_hazard/rdR_hazard   read ports targeting the register being written
//
// Build option REGARB_RR_EN: round-robin arbitration instead of fixed priority A over B.
module regfile_write_arbiter #(
    parameter int DATA_W        = 8,
    parameter int ADDR_W        = 2,
    parameter int STROBE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              _reset,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              _wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              last_grant,
    input  logic [ADDR_W-1:0] rdL_addr,
    input  logic [ADDR_W-1:0] rdR_addr,
    output logic              rdL_hazard,
    output logic              rdR_hazard
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    state_t            state_q;
    logic [1:0]        cnt_q;
    logic              wr_en_n_q;
    logic              last_grant_q;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              grant_b, accept, idle, rst_act;

    assign idle    = state_q == IDLE;
    assign rst_act = !_reset;

`ifdef REGARB_RR_EN
    // Contention goes to the requester that lost last time.
    assign grant_b = b_valid && (!a_valid || !last_grant_q);
`else
    assign grant_b = b_valid && !a_valid;
`endif

    // Ready is gated by reset so no transfer is signalled while the FSM is held.
    assign a_ready   = _reset && idle && a_valid && !grant_b;
    assign b_ready   = _reset && idle && grant_b;
    assign accept    = a_ready || b_ready;
    assign wr_addr_d = rst_act ? '0 : grant_b ? b_addr : a_addr;
    assign wr_data_d = rst_act ? '0 : grant_b ? b_data : a_data;

    always_ff @(posedge clk or negedge _reset) begin
        if (!_reset) begin
            state_q      <= IDLE;
            wr_en_n_q    <= 1'b1;
            last_grant_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    state_q      <= SETUP;
                    last_grant_q <= grant_b;
                end
                SETUP: begin
                    state_q   <= STROBE;
                    wr_en_n_q <= 1'b0;
                    cnt_q     <= 2'(STROBE_CYCLES - 1);
                end
                STROBE: if (cnt_q == '0) begin
                    state_q   <= HOLD;
                    wr_en_n_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q - 2'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // No async clear here: the address/data must survive a reset that cuts a strobe short,
    // because the register file commits on that early rising edge of _wr_en.
    always_ff @(posedge clk) begin
        if (rst_act || accept) begin
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign _wr_en     = wr_en_n_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = !idle;
    assign last_grant = last_grant_q;
    assign rdL_hazard = busy && (rdL_addr == wr_addr_q);
    assign rdR_hazard = busy && (rdR_addr == wr_addr_q);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, strobe sequencing, hazards and reset
module tb_regfile_write_arbiter;
`ifdef REGARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk, _reset, a_valid, b_valid;
    logic [1:0] a_addr, b_addr, rdL_addr, rdR_addr;
    logic [7:0] a_data, b_data;

    logic       a_ready, b_ready, _wr_en, busy, last_grant, rdL_hazard, rdR_hazard;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;

    logic       a_ready3, b_ready3, _wr_en3, busy3, last_grant3, rdL_hazard3, rdR_hazard3;
    logic [1:0] wr_addr3;
    logic [7:0] wr_data3;

    logic [7:0] rf [4];
    int         nfall, n0, checks, errors;
    logic [4:0] pat;

    regfile_write_arbiter dut (
        .clk(clk), ._reset(_reset),
        .a_valid(a_valid), .a_ready(a_ready), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_addr(b_addr), .b_data(b_data),
        ._wr_en(_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .last_grant(last_grant),
        .rdL_addr(rdL_addr), .rdR_addr(rdR_addr),
        .rdL_hazard(rdL_hazard), .rdR_hazard(rdR_hazard)
    );

    regfile_write_arbiter #(.STROBE_CYCLES(3)) dut3 (
        .clk(clk), ._reset(_reset),
        .a_valid(a_valid), .a_ready(a_ready3), .a_addr(a_addr), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready3), .b_addr(b_addr), .b_data(b_data),
        ._wr_en(_wr_en3), .wr_addr(wr_addr3), .wr_data(wr_data3),
        .busy(busy3), .last_grant(last_grant3),
        .rdL_addr(rdL_addr), .rdR_addr(rdR_addr),
        .rdL_hazard(rdL_hazard3), .rdR_hazard(rdR_hazard3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: latches on the rising edge of the strobe.
    always @(posedge _wr_en) if (!$isunknown(wr_addr)) rf[wr_addr] = wr_data;
    always @(negedge _wr_en) nfall++;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks = 0; errors = 0; nfall = 0;
        for (int i = 0; i < 4; i++) rf[i] = 8'h00;
        _reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
        a_addr = '0; b_addr = '0; a_data = '0; b_data = '0; rdL_addr = '0; rdR_addr = '0;
        #1 _reset = 1'b0;
        a_valid = 1'b1;
        repeat (2) tick;
        chk("rst_wr_en", 32'(_wr_en), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_last_grant", 32'(last_grant), 32'd0);
        chk("rst_a_ready", 32'(a_ready), 32'd0);
        chk("rst_b_ready", 32'(b_ready), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        a_valid = 1'b0;
        _reset = 1'b1;

        // Single A write: r2 = 0x5A
        a_valid = 1'b1; a_addr = 2'd2; a_data = 8'h5A;
        #1;
        chk("t1_a_ready", 32'(a_ready), 32'd1);
        chk("t1_b_ready", 32'(b_ready), 32'd0);
        tick;
        a_valid = 1'b0;
        chk("t1_setup_wr_en", 32'(_wr_en), 32'd1);
        chk("t1_setup_busy", 32'(busy), 32'd1);
        chk("t1_setup_addr", 32'(wr_addr), 32'd2);
        chk("t1_setup_data", 32'(wr_data), 32'h5A);
        tick;
        chk("t1_strobe_wr_en", 32'(_wr_en), 32'd0);
        chk("t1_strobe_busy", 32'(busy), 32'd1);
        chk("t1_strobe_data", 32'(wr_data), 32'h5A);
        tick;
        chk("t1_hold_wr_en", 32'(_wr_en), 32'd1);
        chk("t1_hold_busy", 32'(busy), 32'd1);
        chk("t1_hold_addr", 32'(wr_addr), 32'd2);
        tick;
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_rf2", 32'(rf[2]), 32'h5A);

        // Simultaneous requests: A r1 = 0x11, B r3 = 0x33
        a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h11;
        b_valid = 1'b1; b_addr = 2'd3; b_data = 8'h33;
        #1;
        chk("t2_a_ready", 32'(a_ready), 32'(!RR));
        chk("t2_b_ready", 32'(b_ready), 32'(RR));
        tick;
        if (RR) b_valid = 1'b0; else a_valid = 1'b0;
        chk("t2_grant1", 32'(last_grant), 32'(RR));
        chk("t2_addr1", 32'(wr_addr), RR ? 32'd3 : 32'd1);
        chk("t2_busy_a_ready", 32'(a_ready), 32'd0);
        chk("t2_busy_b_ready", 32'(b_ready), 32'd0);
        repeat (3) tick;
        chk("t2_idle_busy", 32'(busy), 32'd0);
        chk("t2_a_ready2", 32'(a_ready), 32'(RR));
        chk("t2_b_ready2", 32'(b_ready), 32'(!RR));
        tick;
        a_valid = 1'b0; b_valid = 1'b0;
        chk("t2_grant2", 32'(last_grant), 32'(!RR));
        chk("t2_addr2", 32'(wr_addr), RR ? 32'd1 : 32'd3);
        repeat (3) tick;
        chk("t2_rf1", 32'(rf[1]), 32'h11);
        chk("t2_rf3", 32'(rf[3]), 32'h33);

        // Back-to-back A writes to r0: 0x01 then 0x02
        n0 = nfall;
        a_valid = 1'b1; a_addr = 2'd0; a_data = 8'h01;
        #1;
        chk("t3_ready1", 32'(a_ready), 32'd1);
        tick;
        a_data = 8'h02;
        for (int i = 1; i <= 3; i++) begin
            chk("t3_ready_busy", 32'(a_ready), 32'd0);
            tick;
        end
        chk("t3_ready2", 32'(a_ready), 32'd1);
        chk("t3_rf0_first", 32'(rf[0]), 32'h01);
        tick;
        a_valid = 1'b0;
        repeat (3) tick;
        chk("t3_pulses", 32'(nfall - n0), 32'd2);
        chk("t3_rf0", 32'(rf[0]), 32'h02);

        // Hazards while r1 is being written
        rdL_addr = 2'd1; rdR_addr = 2'd2;
        a_valid = 1'b1; a_addr = 2'd1; a_data = 8'hAA;
        #1;
        chk("t4_idle_hzL", 32'(rdL_hazard), 32'd0);
        chk("t4_idle_hzR", 32'(rdR_hazard), 32'd0);
        tick;
        a_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_hzL", 32'(rdL_hazard), 32'd1);
            chk("t4_hzR", 32'(rdR_hazard), 32'd0);
            tick;
        end
        chk("t4_end_hzL", 32'(rdL_hazard), 32'd0);
        chk("t4_end_hzR", 32'(rdR_hazard), 32'd0);

        // Reset mid-strobe of r3 = 0xC3
        n0 = nfall;
        a_valid = 1'b1; a_addr = 2'd3; a_data = 8'hC3;
        tick;
        a_valid = 1'b0;
        tick;
        chk("t5_strobe", 32'(_wr_en), 32'd0);
        #2 _reset = 1'b0;
        #1;
        chk("t5_async_wr_en", 32'(_wr_en), 32'd1);
        chk("t5_async_busy", 32'(busy), 32'd0);
        chk("t5_rf3", 32'(rf[3]), 32'hC3);
        _reset = 1'b1;
        repeat (6) tick;
        chk("t5_no_restrobe", 32'(nfall - n0), 32'd1);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("t5_wr_en_high", 32'(_wr_en), 32'd1);

        // STROBE_CYCLES = 3 instance
        pat = 5'b10001;
        a_valid = 1'b1; a_addr = 2'd2; a_data = 8'h77;
        #1;
        chk("t6_ready1", 32'(a_ready3), 32'd1);
        tick;
        a_data = 8'h78;
        for (int i = 0; i < 5; i++) begin
            chk("t6_wr_en", 32'(_wr_en3), 32'(pat[i]));
            chk("t6_ready_busy", 32'(a_ready3), 32'd0);
            chk("t6_busy", 32'(busy3), 32'd1);
            tick;
        end
        chk("t6_ready2", 32'(a_ready3), 32'd1);
        chk("t6_idle", 32'(busy3), 32'd0);
        tick;
        a_valid = 1'b0;
        chk("t6_data2", 32'(wr_data3), 32'h78);
        repeat (8) tick;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
